// File: rtl/sumador_ventana_if.sv
// Sample/result bundle between the ADC front end, the window accumulator and the comparator.
// master = sample source / result consumer, slave = accumulator.
interface sumador_ventana_if;
    logic        iEnable;
    logic        iValid;
    logic [9:0]  ivMuestra;
    logic [9:0]  ivOffset;
    logic        iClear;
    logic [13:0] ovSuma;
    logic        oCE;
    logic [5:0]  ovCuenta;

    modport master (
        output iEnable, iValid, ivMuestra, ivOffset, iClear,
        input  ovSuma, oCE, ovCuenta
    );
    modport slave (
        input  iEnable, iValid, ivMuestra, ivOffset, iClear,
        output ovSuma, oCE, ovCuenta
    );
endinterface

// File: rtl/sumador_ventana.sv
// Windowed flow-sample accumulator: sums offset-clamped samples over WINDOW accepts, saturating at 14 bits.
// Define SUMADOR_PICO_EN for peak-hold mode (ovSuma only rises on window completion).
module sumador_ventana #(
    parameter int WINDOW = 16
) (
    input  logic iClk,
    input  logic iReset,
    sumador_ventana_if.slave bus
);
    typedef enum logic {IDLE, ACUM} estado_t;

    localparam logic [5:0]  ULTIMO = 6'(WINDOW - 1);
    localparam logic [14:0] TOPE   = 15'd16383;

    estado_t     estado, estadoSig;
    logic [14:0] acumulador;
    logic [5:0]  cuenta;
    logic [13:0] suma;
    logic        ce;

    logic        aceptado;
    logic        fin;
    logic [9:0]  aporte;
    logic [14:0] sumaBruta;
    logic [13:0] sumaSat;

    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) estado <= IDLE;
        else         estado <= estadoSig;
    end

    always_comb begin
        estadoSig = estado;
        aceptado  = 1'b0;
        case (estado)
            IDLE: if (bus.iEnable) estadoSig = ACUM;
            ACUM: begin
                if (!bus.iEnable) estadoSig = IDLE;
                else              aceptado  = bus.iValid && !bus.iClear;
            end
            default: estadoSig = IDLE;
        endcase
    end

    // Negative contributions clamp to zero; the accumulator stays saturated so the add never overflows 15 bits.
    always_comb begin
        aporte    = (bus.ivMuestra > bus.ivOffset) ? (bus.ivMuestra - bus.ivOffset) : 10'd0;
        sumaBruta = acumulador + 15'(aporte);
        sumaSat   = (sumaBruta > TOPE) ? 14'h3FFF : sumaBruta[13:0];
        fin       = aceptado && (cuenta == ULTIMO);
    end

    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            acumulador <= '0;
            cuenta     <= '0;
            suma       <= '0;
            ce         <= 1'b0;
        end else begin
            ce <= 1'b0;
            if (bus.iClear) begin
                acumulador <= '0;
                cuenta     <= '0;
                suma       <= '0;
            end else if (estado == IDLE || !bus.iEnable) begin
                acumulador <= '0;
                cuenta     <= '0;
            end else if (fin) begin
                acumulador <= '0;
                cuenta     <= '0;
                ce         <= 1'b1;
`ifdef SUMADOR_PICO_EN
                if (sumaSat > suma) suma <= sumaSat;
`else
                suma <= sumaSat;
`endif
            end else if (aceptado) begin
                acumulador <= {1'b0, sumaSat};
                cuenta     <= cuenta + 6'd1;
            end
        end
    end

    assign bus.ovSuma   = suma;
    assign bus.oCE      = ce;
    assign bus.ovCuenta = cuenta;
endmodule

// File: tb/tb_sumador_ventana.sv
// Bench for sumador_ventana: directed test-plan steps plus random traffic against a queue-based window model.
module tb_sumador_ventana;
    logic iClk = 1'b0;
    logic iReset = 1'b0;
    always #5 iClk = ~iClk;

    sumador_ventana_if busA ();
    sumador_ventana_if busB ();

    sumador_ventana #(.WINDOW(16)) dutA (.iClk(iClk), .iReset(iReset), .bus(busA));
    sumador_ventana #(.WINDOW(32)) dutB (.iClk(iClk), .iReset(iReset), .bus(busB));

    int vectors = 0;
    int miscompares = 0;

    // Reference: the current window is a list of contributions; it closes when WINDOW entries are present.
    int unsigned ventana[$];
    int unsigned expSuma = 0;
    bit          expCE = 1'b0;
    bit          midiendo = 1'b0;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        check({tag, "_suma"},   int'(busA.ovSuma),   int'(expSuma));
        check({tag, "_ce"},     int'(busA.oCE),      int'(expCE));
        check({tag, "_cuenta"}, int'(busA.ovCuenta), ventana.size());
    endtask

    task automatic step(input bit en, input bit val, input int m, input int off, input bit clr);
        int unsigned s;
        @(negedge iClk);
        busA.iEnable = en; busA.iValid = val; busA.iClear = clr;
        busA.ivMuestra = 10'(m); busA.ivOffset = 10'(off);
        @(posedge iClk);
        expCE = 1'b0;
        if (clr) begin
            ventana.delete();
            expSuma = 0;
        end else if (midiendo && en) begin
            if (val) begin
                ventana.push_back((m > off) ? m - off : 0);
                if (ventana.size() == 16) begin
                    s = 0;
                    foreach (ventana[i]) s += ventana[i];
                    if (s > 16383) s = 16383;
                    ventana.delete();
                    expCE = 1'b1;
`ifdef SUMADOR_PICO_EN
                    if (s > expSuma) expSuma = s;
`else
                    expSuma = s;
`endif
                end
            end
        end else begin
            ventana.delete();
        end
        midiendo = en;
        #1 checkAll("step");
    endtask

    task automatic window(input int n, input int m, input int off);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, m, off, 1'b0);
    endtask

    initial begin
        busA.iEnable = 0; busA.iValid = 0; busA.iClear = 0; busA.ivMuestra = 0; busA.ivOffset = 0;
        busB.iEnable = 0; busB.iValid = 0; busB.iClear = 0; busB.ivMuestra = 0; busB.ivOffset = 0;
        #12;
        check("rst_suma", int'(busA.ovSuma), 0);
        check("rst_ce", int'(busA.oCE), 0);
        check("rst_cuenta", int'(busA.ovCuenta), 0);
        @(negedge iClk); iReset = 1'b1;

        // Two back-to-back windows of 100s
        step(1, 0, 0, 0, 0);
        window(16, 100, 0);
        check("w1_suma", int'(busA.ovSuma), 1600);
        check("w1_ce", int'(busA.oCE), 1);
        step(1, 0, 0, 0, 0);
        check("w1_ce_fall", int'(busA.oCE), 0);
        window(16, 100, 0);
        check("w2_suma", int'(busA.ovSuma), 1600);

        // Offset clamp
        step(1, 0, 0, 0, 1);
        window(16, 50, 80);
        check("clamp_suma", int'(busA.ovSuma), 0);
        check("clamp_ce", int'(busA.oCE), 1);
        window(16, 300, 80);
        check("off_suma", int'(busA.ovSuma), 3520);

        // Peak hold versus plain load
        step(1, 0, 0, 0, 1);
        window(16, 100, 0);
        check("pk1_suma", int'(busA.ovSuma), 1600);
        window(16, 50, 0);
        check("pk2_ce", int'(busA.oCE), 1);
`ifdef SUMADOR_PICO_EN
        check("pk2_suma", int'(busA.ovSuma), 1600);
`else
        check("pk2_suma", int'(busA.ovSuma), 800);
`endif

        // Enable dropped mid-window, sample on the falling cycle is not accepted
        window(10, 100, 0);
        check("dis_cuenta10", int'(busA.ovCuenta), 10);
        step(0, 1, 100, 0, 0);
        check("dis_cuenta", int'(busA.ovCuenta), 0);
        check("dis_ce", int'(busA.oCE), 0);
        step(1, 1, 100, 0, 0);
        check("reen_cuenta", int'(busA.ovCuenta), 0);
        window(15, 100, 0);
        check("reen_ce15", int'(busA.oCE), 0);
        window(1, 100, 0);
        check("reen_ce", int'(busA.oCE), 1);

        // Clear colliding with the 16th sample
        window(15, 100, 0);
        step(1, 1, 100, 0, 1);
        check("clr_suma", int'(busA.ovSuma), 0);
        check("clr_ce", int'(busA.oCE), 0);
        check("clr_cuenta", int'(busA.ovCuenta), 0);
        window(16, 100, 0);
        check("clr_next_suma", int'(busA.ovSuma), 1600);

        // Reset mid-window: outputs clear asynchronously
        step(1, 0, 0, 0, 1);
        window(16, 200, 0);
        window(7, 100, 0);
        @(negedge iClk); #2 iReset = 1'b0;
        #1;
        check("amid_suma", int'(busA.ovSuma), 0);
        check("amid_ce", int'(busA.oCE), 0);
        check("amid_cuenta", int'(busA.ovCuenta), 0);
        ventana.delete(); expSuma = 0; expCE = 0; midiendo = 0;
        busA.iEnable = 0; busA.iValid = 0;
        @(negedge iClk); iReset = 1'b1;

        // Saturation on the 32-sample instance
        @(negedge iClk); busB.iEnable = 1;
        @(negedge iClk); busB.iValid = 1; busB.ivMuestra = 10'd1023; busB.ivOffset = 10'd0;
        for (int i = 0; i < 31; i++) @(negedge iClk);
        check("sat_cuenta31", int'(busB.ovCuenta), 31);
        check("sat_ce31", int'(busB.oCE), 0);
        @(negedge iClk); busB.iValid = 0;
        check("sat_suma", int'(busB.ovSuma), 16383);
        check("sat_ce", int'(busB.oCE), 1);
        check("sat_cuenta", int'(busB.ovCuenta), 0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 19) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1023), $urandom_range(0, 400), $urandom_range(0, 59) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
